video_slot_sequencer: RTL and testbench

//  Parametrised successor to the fixed 32-cycle CGA sequencer. A free-running

---
 rtl/video_seq_pkg.sv | 35 +++
 rtl/seq_isa_arbiter.sv | 101 ++++++++++
 rtl/video_slot_sequencer.sv | 155 +++++++++++++++
 tb/tb_video_slot_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_seq_pkg.sv
// Shared definitions for the video slot sequencer.
// Contents:
//   - offsets inside a character slot of each strobe
//   - ISA grant FSM state encoding
//   - mode saturation helper
package video_seq_pkg;

    // Offsets inside an active slot (or inside a fine slot for the VRAM read strobes)
    localparam int OFF_CRTC = 0;
    localparam int OFF_RD0  = 1;  // first VRAM read cycle of a fine slot
    localparam int OFF_RD1  = 3;  // last VRAM read cycle of a fine slot
    localparam int OFF_A0   = 2;
    localparam int OFF_CHAR = 2;
    localparam int OFF_ATT  = 3;
    localparam int OFF_PIPE = 4;
    localparam int ISA_LO   = 5;  // first fine offset where an ISA access may run

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } isa_state_e;

    // Clamp a requested log2 slot count to the largest supported value
    function automatic logic [1:0] sat_mode(input logic [1:0] mode_req, input int max_lslots);
        logic [1:0] result;
        if (int'(mode_req) > max_lslots) begin
            result = 2'(max_lslots);
        end else begin
            result = mode_req;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_isa_arbiter.sv
// ISA grant FSM for the video slot sequencer.
// Grants an ISA VRAM access only inside the legal window of a fine slot, keeps
// it busy for ISA_LEN cycles and defers a phase clear until the access is over.
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   isa_req         level: ISA access pending
//   grant_ok        the current fine offset is inside the grant window
//   phase_clr       pulse: divider restart requested
//   isa_grant       1-cycle pulse, the access may start next cycle
//   isa_busy        high for ISA_LEN cycles after the grant
//   phase_apply     the divider must restart at 0 on the next edge
module seq_isa_arbiter
    import video_seq_pkg::*;
#(
    parameter int ISA_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic isa_req,
    input  logic grant_ok,
    input  logic phase_clr,
    output logic isa_grant,
    output logic isa_busy,
    output logic phase_apply
);

    localparam int BC_W = (ISA_LEN > 1) ? $clog2(ISA_LEN) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(ISA_LEN - 1);

    isa_state_e      state_r;
    isa_state_e      state_nx_s;
    isa_state_e      state_cur_s;
    logic [BC_W-1:0] busy_cnt_r;
    logic [BC_W-1:0] busy_cnt_nx_s;
    logic            phase_pend_r;
    logic            phase_pend_nx_s;

    // State register, busy counter and pending phase clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            busy_cnt_r   <= '0;
            phase_pend_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            busy_cnt_r   <= busy_cnt_nx_s;
            phase_pend_r <= phase_pend_nx_s;
        end
    end

    // Next-state logic. The grant cycle is the IDLE cycle in which a legal
    // request is seen, so state_cur_s reports GRANT for that cycle.
    always_comb begin
        state_cur_s     = state_r;
        state_nx_s      = state_r;
        busy_cnt_nx_s   = busy_cnt_r;
        phase_pend_nx_s = phase_pend_r;
        phase_apply     = 1'b0;
        case (state_r)
            IDLE: begin
                if (isa_req && grant_ok) begin
                    state_cur_s     = GRANT;
                    state_nx_s      = BUSY;
                    busy_cnt_nx_s   = '0;
                    phase_pend_nx_s = phase_clr;
                end else begin
                    phase_apply     = phase_clr;
                    phase_pend_nx_s = 1'b0;
                end
            end
            GRANT: begin
                state_nx_s      = BUSY;
                busy_cnt_nx_s   = '0;
                phase_pend_nx_s = phase_pend_r | phase_clr;
            end
            BUSY: begin
                if (busy_cnt_r == BC_LAST) begin
                    // Access ends on this edge: a deferred clear lands here
                    state_nx_s      = IDLE;
                    phase_apply     = phase_pend_r | phase_clr;
                    phase_pend_nx_s = 1'b0;
                end else begin
                    busy_cnt_nx_s   = busy_cnt_r + BC_W'(1);
                    phase_pend_nx_s = phase_pend_r | phase_clr;
                end
            end
            default: begin
                state_nx_s      = IDLE;
                busy_cnt_nx_s   = '0;
                phase_pend_nx_s = 1'b0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        isa_grant = (state_cur_s == GRANT);
        isa_busy  = (state_r == BUSY);
    end

endmodule

// File: rtl/video_slot_sequencer.sv
// Video slot sequencer: free-running divider that times VRAM reads, char-ROM
// reads, CRTC clocks and the display pipeline in 1..2**MAX_LSLOTS character
// slots per period, plus an ISA VRAM access arbiter with a guard gap.
// Ports:
//   clk, reset_n       pixel clock, asynchronous active-low reset
//   mode               log2 active slots per period (saturates at MAX_LSLOTS)
//   phase_clr          pulse: restart the divider at 0
//   isa_req            level: ISA access pending
//   clk_seq            divider value
//   lclk / hclk        strobes at 0 / at 0 and PERIOD/2
//   crtc_clk, vram_read_char, vram_read_att, charrom_read, disp_pipeline
//                      active-slot strobes
//   vram_read, vram_read_a0   fine-slot strobes (mode independent)
//   slot_idx           current active slot
//   isa_op_enable, isa_grant, isa_busy   ISA access window and handshake
module video_slot_sequencer
    import video_seq_pkg::*;
#(
    parameter int DIV_W      = 5,
    parameter int MAX_LSLOTS = 1,
    parameter int ISA_LEN    = 3,
    parameter int GUARD      = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic             phase_clr,
    input  logic             isa_req,
    output logic [DIV_W-1:0] clk_seq,
    output logic             lclk,
    output logic             hclk,
    output logic             crtc_clk,
    output logic             vram_read,
    output logic             vram_read_a0,
    output logic             vram_read_char,
    output logic             vram_read_att,
    output logic             charrom_read,
    output logic             disp_pipeline,
    output logic [1:0]       slot_idx,
    output logic             isa_op_enable,
    output logic             isa_grant,
    output logic             isa_busy
);

    localparam int PERIOD    = 2 ** DIV_W;
    localparam int FS        = PERIOD >> MAX_LSLOTS;
    localparam int FOFF_W    = DIV_W - MAX_LSLOTS;
    localparam int GRANT_MAX = FS - 1 - GUARD - ISA_LEN;

    localparam logic [DIV_W-1:0]  CNT_MASK  = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0]  CNT_LAST  = DIV_W'(PERIOD - 1);
    localparam logic [DIV_W-1:0]  CNT_HALF  = DIV_W'(PERIOD / 2);
    localparam logic [DIV_W-1:0]  A_CRTC    = DIV_W'(OFF_CRTC);
    localparam logic [DIV_W-1:0]  A_CHAR    = DIV_W'(OFF_CHAR);
    localparam logic [DIV_W-1:0]  A_ATT     = DIV_W'(OFF_ATT);
    localparam logic [DIV_W-1:0]  A_PIPE    = DIV_W'(OFF_PIPE);
    localparam logic [FOFF_W-1:0] F_RD0     = FOFF_W'(OFF_RD0);
    localparam logic [FOFF_W-1:0] F_RD1     = FOFF_W'(OFF_RD1);
    localparam logic [FOFF_W-1:0] F_A0      = FOFF_W'(OFF_A0);
    localparam logic [FOFF_W-1:0] F_ISA_LO  = FOFF_W'(ISA_LO);
    localparam logic [FOFF_W-1:0] F_ISA_HI  = FOFF_W'(FS - 2);
    localparam logic [FOFF_W-1:0] F_GNT_MAX = FOFF_W'(GRANT_MAX);

    generate
        if (FS < 4 + ISA_LEN + GUARD + 2) begin : g_fs_check
            $error("video_slot_sequencer: fine slot too short for the ISA access and guard gap");
        end
    endgenerate

    logic [DIV_W-1:0]  cnt_r;
    logic              run_r;
    logic [1:0]        mode_q_r;
    logic [1:0]        mode_sat_s;
    logic [DIV_W-1:0]  off_s;
    logic [FOFF_W-1:0] fine_off_s;
    logic [DIV_W-1:0]  slot_full_s;
    logic              isa_win_s;
    logic              grant_ok_s;
    logic              phase_apply_s;

    // Mode value that would be loaded at the next period boundary
    always_comb begin
        mode_sat_s = sat_mode(mode, MAX_LSLOTS);
    end

    // Divider, run flag and mode register. mode only changes at a period
    // boundary or on a phase clear, so no partial slot is ever produced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r    <= '0;
            run_r    <= 1'b0;
            mode_q_r <= 2'd0;
        end else if (!run_r) begin
            run_r <= 1'b1;
        end else if (phase_apply_s) begin
            cnt_r    <= '0;
            mode_q_r <= mode_sat_s;
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
            if (cnt_r == CNT_LAST) begin
                mode_q_r <= mode_sat_s;
            end
        end
    end

    // Strobe decode from the registered divider and mode
    always_comb begin
        off_s          = cnt_r & (CNT_MASK >> mode_q_r);
        fine_off_s     = cnt_r[FOFF_W-1:0];
        slot_full_s    = cnt_r >> (DIV_W - int'(mode_q_r));
        clk_seq        = cnt_r;
        slot_idx       = slot_full_s[1:0];
        lclk           = 1'b0;
        hclk           = 1'b0;
        crtc_clk       = 1'b0;
        vram_read      = 1'b0;
        vram_read_a0   = 1'b0;
        vram_read_char = 1'b0;
        vram_read_att  = 1'b0;
        charrom_read   = 1'b0;
        disp_pipeline  = 1'b0;
        isa_win_s      = 1'b0;
        if (run_r) begin
            lclk           = (cnt_r == '0);
            hclk           = (cnt_r == '0) || (cnt_r == CNT_HALF);
            crtc_clk       = (off_s == A_CRTC);
            vram_read      = (fine_off_s >= F_RD0) && (fine_off_s <= F_RD1);
            vram_read_a0   = (fine_off_s == F_A0);
            vram_read_char = (off_s == A_CHAR);
            vram_read_att  = (off_s == A_ATT);
            charrom_read   = (off_s == A_ATT);
            disp_pipeline  = (off_s == A_PIPE);
            isa_win_s      = (fine_off_s >= F_ISA_LO) && (fine_off_s <= F_ISA_HI);
        end else begin
            isa_win_s = 1'b0;
        end
        isa_op_enable = isa_win_s;
        // Late grants are refused so the access plus guard ends before the next read
        grant_ok_s    = isa_win_s && (fine_off_s <= F_GNT_MAX);
    end

    seq_isa_arbiter #(
        .ISA_LEN (ISA_LEN)
    ) u_isa_arbiter (
        .clk         (clk),
        .reset_n     (reset_n),
        .isa_req     (isa_req),
        .grant_ok    (grant_ok_s),
        .phase_clr   (phase_clr),
        .isa_grant   (isa_grant),
        .isa_busy    (isa_busy),
        .phase_apply (phase_apply_s)
    );

endmodule

// File: tb/tb_video_slot_sequencer.sv
// Directed bench for video_slot_sequencer: default instance plus a
// DIV_W=6 / MAX_LSLOTS=2 instance for the saturation case.
module tb_video_slot_sequencer;

    logic       clk;
    logic       reset_n;
    logic [1:0] mode;
    logic       phase_clr;
    logic       isa_req;
    logic [1:0] mode6;
    logic       phase_clr6;
    logic       isa_req6;

    logic [4:0] clk_seq;
    logic lclk, hclk, crtc_clk, vram_read, vram_read_a0, vram_read_char;
    logic vram_read_att, charrom_read, disp_pipeline, isa_op_enable, isa_grant, isa_busy;
    logic [1:0] slot_idx;

    logic [5:0] clk_seq6;
    logic lclk6, hclk6, crtc_clk6, vram_read6, vram_read_a06, vram_read_char6;
    logic vram_read_att6, charrom_read6, disp_pipeline6, isa_op_enable6, isa_grant6, isa_busy6;
    logic [1:0] slot_idx6;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    video_slot_sequencer dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .phase_clr(phase_clr), .isa_req(isa_req),
        .clk_seq(clk_seq), .lclk(lclk), .hclk(hclk), .crtc_clk(crtc_clk),
        .vram_read(vram_read), .vram_read_a0(vram_read_a0), .vram_read_char(vram_read_char),
        .vram_read_att(vram_read_att), .charrom_read(charrom_read), .disp_pipeline(disp_pipeline),
        .slot_idx(slot_idx), .isa_op_enable(isa_op_enable), .isa_grant(isa_grant), .isa_busy(isa_busy)
    );

    video_slot_sequencer #(.DIV_W(6), .MAX_LSLOTS(2), .ISA_LEN(3), .GUARD(2)) dut6 (
        .clk(clk), .reset_n(reset_n), .mode(mode6), .phase_clr(phase_clr6), .isa_req(isa_req6),
        .clk_seq(clk_seq6), .lclk(lclk6), .hclk(hclk6), .crtc_clk(crtc_clk6),
        .vram_read(vram_read6), .vram_read_a0(vram_read_a06), .vram_read_char(vram_read_char6),
        .vram_read_att(vram_read_att6), .charrom_read(charrom_read6), .disp_pipeline(disp_pipeline6),
        .slot_idx(slot_idx6), .isa_op_enable(isa_op_enable6), .isa_grant(isa_grant6), .isa_busy(isa_busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_cnt(input logic [4:0] target);
        for (int k = 0; k < 200 && clk_seq !== target; k++) tick();
        if (clk_seq !== target) check("wait_cnt_timeout", 64'(clk_seq), 64'(target));
    endtask

    // Sample one 32-cycle period starting at the current cycle (clk_seq must be 0)
    task automatic scan(output logic [31:0] lc, output logic [31:0] hc, output logic [31:0] cr,
                        output logic [31:0] vr, output logic [31:0] a0, output logic [31:0] ch,
                        output logic [31:0] at, output logic [31:0] cm, output logic [31:0] pp,
                        output logic [31:0] oe, output logic [31:0] sl, output int seq_bad);
        seq_bad = 0;
        for (int i = 0; i < 32; i++) begin
            lc[i] = lclk;           hc[i] = hclk;          cr[i] = crtc_clk;
            vr[i] = vram_read;      a0[i] = vram_read_a0;  ch[i] = vram_read_char;
            at[i] = vram_read_att;  cm[i] = charrom_read;  pp[i] = disp_pipeline;
            oe[i] = isa_op_enable;  sl[i] = slot_idx[0];
            if (clk_seq !== 5'(i)) seq_bad++;
            tick();
        end
    endtask

    logic [31:0] v_lc, v_hc, v_cr, v_vr, v_a0, v_ch, v_at, v_cm, v_pp, v_oe, v_sl;
    int          v_seq_bad;
    logic [63:0] c6_cr, c6_vr, c6_hc;
    logic [7:0]  c6_sl;
    int          ovl_cnt, gap_cnt, gnt_cnt, since_busy;
    logic        seen;

    initial begin
        reset_n = 1'b1; mode = 2'd0; phase_clr = 1'b0; isa_req = 1'b0;
        mode6 = 2'd3; phase_clr6 = 1'b0; isa_req6 = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_clk_seq", 64'(clk_seq), 64'd0);
        check("rst_strobes", 64'({lclk, hclk, crtc_clk, vram_read, vram_read_char, disp_pipeline}), 64'd0);
        check("rst_isa", 64'({isa_op_enable, isa_grant, isa_busy}), 64'd0);

        // Test 1: release, mode 0
        reset_n = 1'b1;
        tick();
        check("start_lclk_hclk_crtc", 64'({lclk, hclk, crtc_clk}), 64'h7);
        scan(v_lc, v_hc, v_cr, v_vr, v_a0, v_ch, v_at, v_cm, v_pp, v_oe, v_sl, v_seq_bad);
        check("m0_count_seq", 64'(v_seq_bad), 64'd0);
        check("m0_lclk", 64'(v_lc), 64'h0000_0001);
        check("m0_hclk", 64'(v_hc), 64'h0001_0001);
        check("m0_crtc", 64'(v_cr), 64'h0000_0001);
        check("m0_vram_read", 64'(v_vr), 64'h000E_000E);
        check("m0_a0", 64'(v_a0), 64'h0004_0004);
        check("m0_char", 64'(v_ch), 64'h0000_0004);
        check("m0_att", 64'(v_at), 64'h0000_0008);
        check("m0_charrom", 64'(v_cm), 64'h0000_0008);
        check("m0_pipe", 64'(v_pp), 64'h0000_0010);
        check("m0_op_enable", 64'(v_oe), 64'h7FE0_7FE0);
        check("m0_slot", 64'(v_sl), 64'h0000_0000);

        // Test 2: mode 1 takes effect from the next period boundary
        mode = 2'd1;
        repeat (32) tick();
        scan(v_lc, v_hc, v_cr, v_vr, v_a0, v_ch, v_at, v_cm, v_pp, v_oe, v_sl, v_seq_bad);
        check("m1_count_seq", 64'(v_seq_bad), 64'd0);
        check("m1_hclk", 64'(v_hc), 64'h0001_0001);
        check("m1_crtc", 64'(v_cr), 64'h0001_0001);
        check("m1_vram_read", 64'(v_vr), 64'h000E_000E);
        check("m1_char", 64'(v_ch), 64'h0004_0004);
        check("m1_att", 64'(v_at), 64'h0008_0008);
        check("m1_pipe", 64'(v_pp), 64'h0010_0010);
        check("m1_slot", 64'(v_sl), 64'hFFFF_0000);

        // Test 3: mode 0->1 written mid-period
        mode = 2'd0;
        repeat (32) tick();
        repeat (9) tick();
        check("m01_at9", 64'(clk_seq), 64'd9);
        mode = 2'd1;
        repeat (7) tick();
        check("m01_no_crtc16", 64'({clk_seq, crtc_clk}), 64'({5'd16, 1'b0}));
        repeat (16) tick();
        check("m01_crtc0_next", 64'({clk_seq, crtc_clk}), 64'({5'd0, 1'b1}));
        repeat (16) tick();
        check("m01_crtc16_next", 64'({clk_seq, crtc_clk, slot_idx}), 64'({5'd16, 1'b1, 2'd1}));

        // Test 4a: request at cnt 10 is granted immediately
        repeat (26) tick();
        isa_req = 1'b1;
        #1;
        check("isa10_grant", 64'({clk_seq, isa_grant, isa_busy}), 64'({5'd10, 1'b1, 1'b0}));
        tick();
        isa_req = 1'b0;
        #1;
        check("isa11_busy", 64'({clk_seq, isa_grant, isa_busy}), 64'({5'd11, 1'b0, 1'b1}));
        tick();
        check("isa12_busy", 64'(isa_busy), 64'd1);
        tick();
        check("isa13_busy", 64'(isa_busy), 64'd1);
        tick();
        check("isa14_idle", 64'({clk_seq, isa_busy}), 64'({5'd14, 1'b0}));

        // Test 4b: request at cnt 11 waits for the next window
        repeat (29) tick();
        isa_req = 1'b1;
        #1;
        check("isa_late_nogrant", 64'({clk_seq, isa_grant}), 64'({5'd11, 1'b0}));
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            #1;
            seen = isa_grant;
        end
        check("isa_late_grant_at21", 64'({seen, clk_seq}), 64'({1'b1, 5'd21}));
        tick();
        isa_req = 1'b0;
        repeat (3) tick();
        check("isa_late_done", 64'({clk_seq, isa_busy}), 64'({5'd25, 1'b0}));

        // Test 5: phase clear deferred during busy, immediate in idle
        repeat (17) tick();
        isa_req = 1'b1;
        #1;
        check("pc_grant10", 64'({clk_seq, isa_grant}), 64'({5'd10, 1'b1}));
        tick();
        isa_req = 1'b0;
        tick();
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        check("pc_busy_continues", 64'({clk_seq, isa_busy}), 64'({5'd13, 1'b1}));
        tick();
        check("pc_applied_after_busy", 64'({clk_seq, isa_busy}), 64'({5'd0, 1'b0}));
        repeat (7) tick();
        check("pc_idle_at7", 64'(clk_seq), 64'd7);
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        check("pc_idle_cleared", 64'({clk_seq, lclk}), 64'({5'd0, 1'b1}));
        tick();
        check("pc_idle_resume", 64'(clk_seq), 64'd1);

        // Random requests and modes: no overlap and guard gap before every read
        ovl_cnt = 0; gap_cnt = 0; gnt_cnt = 0; since_busy = 255;
        for (int k = 0; k < 10000; k++) begin
            mode    = 2'($urandom_range(0, 3));
            isa_req = 1'($urandom_range(0, 1));
            #1;
            if (isa_busy) since_busy = 0;
            else if (since_busy < 255) since_busy++;
            if (isa_busy && vram_read) ovl_cnt++;
            if (vram_read && !isa_busy && since_busy <= 2) gap_cnt++;
            if (isa_grant) gnt_cnt++;
            tick();
        end
        isa_req = 1'b0;
        mode    = 2'd0;
        check("rand_no_overlap", 64'(ovl_cnt), 64'd0);
        check("rand_guard_gap", 64'(gap_cnt), 64'd0);
        check("rand_grants_seen", 64'(gnt_cnt != 0), 64'd1);

        // Test 6: 64-cycle period, mode 3 saturates to 4 slots
        for (int k = 0; k < 100 && clk_seq6 !== 6'd0; k++) tick();
        check("d6_sync", 64'(clk_seq6), 64'd0);
        for (int i = 0; i < 64; i++) begin
            c6_cr[i] = crtc_clk6;
            c6_vr[i] = vram_read6;
            c6_hc[i] = hclk6;
            if (i % 16 == 0) c6_sl[(i / 16) * 2 +: 2] = slot_idx6;
            tick();
        end
        check("d6_crtc", c6_cr, 64'h0001_0001_0001_0001);
        check("d6_vram_read", c6_vr, 64'h000E_000E_000E_000E);
        check("d6_hclk", c6_hc, 64'h0000_0001_0000_0001);
        check("d6_slot_idx", 64'(c6_sl), 64'hE4);

        // Reset in the middle of an access
        repeat (5) tick();
        wait_cnt(5'd10);
        isa_req = 1'b1;
        #1;
        check("mid_grant", 64'(isa_grant), 64'd1);
        tick();
        isa_req = 1'b0;
        check("mid_busy", 64'(isa_busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_reset", 64'({clk_seq, isa_busy, isa_grant, vram_read, lclk}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
